shifter_pipe: RTL and testbench
===============================

Name: shifter_pipe

Overview:
- Parametrised, pipelined ARM-style barrel shifter for the operand-2 path of the multicycle/pipelined datapath.
- Adds over the combinational shifter:
  - a true arithmetic right shift and ROR/RRX;
  - ARM carry-out;
  - full immediate vs register shift-amount semantics, including amounts of WIDTH and above;
  - a valid/ready handshake with backpressure;
  - a configurable number of register stages, a tag passthrough and a flush input.

Parameters:
WIDTH, 32, data width; power of two, 8..64.
LATENCY, 2, number of register stages from input to output; legal range 1..3.
TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset; clears all state immediately.
flush  in  1  synchronous; drops every in-flight operation.
in_valid  in  1  input operation present.
in_ready  out  1  pipeline can accept input this cycle.
in_rm  in  WIDTH  value to shift.
in_rs  in  WIDTH  register shift amount source; only bits [7:0] are used.
in_shamt  in  log2(WIDTH)  immediate shift amount.
in_sh  in  2  shift type: 00 LSL, 01 LSR, 10 ASR, 11 ROR/RRX.
in_reg  in  1  1 = amount from in_rs[7:0]; 0 = amount from in_shamt.
in_cin  in  1  current C flag, used for the carry default and for RRX.
in_tag  in  TAG_W  passthrough tag.
out_valid  out  1  result present.
out_ready  in  1  consumer accepts the result.
out_y  out  WIDTH  shifted result.
out_cout  out  1  shifter carry-out.
out_tag  out  TAG_W  tag of the result.

Behaviour:

Reset:
- Assertion of reset clears immediately, without waiting for clk: every stage valid bit, out_valid, out_y, out_cout and out_tag, all to 0.
- in_ready is 1 while reset is asserted and after release.

Handshake:
- Global-advance pipeline: adv = out_ready | ~out_valid; in_ready = adv (combinational).
- A transfer in occurs when in_valid & in_ready; a transfer out occurs when out_valid & out_ready.
- When adv = 1, every stage loads from its predecessor and stage 1 loads the input (valid = in_valid).
- When adv = 0, all stages hold.
- Bubbles are not collapsed. Results appear exactly LATENCY cycles after acceptance when out_ready stays high. Throughput is 1 operation per cycle.
- out_y, out_cout and out_tag are stable while out_valid & ~out_ready.
- Data in stages with valid = 0 is don't-care, except that the outputs read 0 after reset.

Flush:
- flush = 1 clears all valid bits at the next edge and overrides adv.
- An input presented in the same cycle is discarded, even though in_ready shows 1.

Amount decode (with W = WIDTH, a = effective amount):
- in_reg = 1: a = in_rs[7:0], range 0..255.
- in_reg = 0, in_shamt != 0: a = in_shamt.
- in_reg = 0, in_shamt = 0:
  - LSL: a = 0.
  - LSR and ASR: a = W.
  - ROR: operation becomes RRX.

Results (y, cout):
- a = 0, not RRX, any type: y = rm, cout = cin.
- LSL:
  - 0 < a < W: y = rm << a, cout = rm[W-a].
  - a = W: y = 0, cout = rm[0].
  - a > W: y = 0, cout = 0.
- LSR:
  - 0 < a < W: y = rm >> a, cout = rm[a-1].
  - a = W: y = 0, cout = rm[W-1].
  - a > W: y = 0, cout = 0.
- ASR:
  - 0 < a < W: sign-filling shift, cout = rm[a-1].
  - a >= W: y = all bits equal to rm[W-1], cout = rm[W-1].
- ROR, with r = a mod W:
  - a != 0, r = 0: y = rm, cout = rm[W-1].
  - r != 0: y = rotate-right of rm by r, cout = y[W-1].
- RRX: y = {cin, rm[W-1:1]}, cout = rm[0].

Stage partitioning:
- The shifter is a log2(W)-level mux network.
- LATENCY = 1: decode plus the full network, then the output register.
- LATENCY = 2: decode plus the low half of the levels → register → the remaining levels → output register.
- LATENCY = 3: decode → register → the network split in halves across the two following registers.
- Carry, the rm[W-1] sign bit, cin and the tag ride along through every stage.
- Functional results are identical for every LATENCY; only the cycle offset differs.

Simultaneous events:
- Reset dominates flush; flush dominates adv.
- With the pipeline full and out_ready = 0, in_ready = 0 and nothing is lost.

Test Plan (WIDTH = 32, LATENCY = 2 unless stated):
- Reset: assert reset mid-stream with 2 operations in flight → out_valid = 0 and out_y = 0 immediately; after release, no stale result appears.
- Immediate encodings:
  - LSR #0 on rm = 0x80000001 → y = 0, cout = 1.
  - ASR #0 on rm = 0x80000000 → y = 0xFFFFFFFF, cout = 1.
  - ROR #0 with cin = 1 on rm = 0x00000003 → y = 0x80000001, cout = 1.
- Register amounts:
  - LSL by 32 on rm = 0x00000001 → y = 0, cout = 1.
  - LSL by 33 → y = 0, cout = 0.
  - ROR by 36 on rm = 0x0000000F → y = 0xF0000000, cout = 1.
  - Amount 0 with cin = 0 → y = rm, cout = 0.
- ASR by 4 on rm = 0xF0000010 → y = 0xFF000001, cout = 0; LSR by 4 on the same rm → y = 0x0F000001, cout = 0.
- Backpressure: stream 8 tagged operations (tags 0..7) while out_ready toggles with a random pattern → all 8 results arrive in order with correct data; in_ready = 0 exactly when out_valid & ~out_ready; the held output is unchanged while stalled.
- Flush and latency: flush while 2 operations are in flight plus 1 presented at input → none of the 3 emerges. Repeat the scenarios with LATENCY = 1 and LATENCY = 3 → identical results, with the first result LATENCY cycles after acceptance.

Source files
------------

// File: rtl/shifter_pipe.sv
// shifter_pipe: pipelined ARM-style barrel shifter for the operand-2 path.
//
// Supported shifts are LSL, LSR, ASR, ROR and RRX. The shifter also produces
// the ARM carry-out. The shift amount comes from an immediate or from
// in_rs[7:0], and register amounts of WIDTH and above are handled.
//
// The pipeline has LATENCY register stages with a global-advance handshake.
// When the output is full and the consumer stalls, every stage holds.
// flush drops every in-flight operation. The tag travels with each result.
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   flush      synchronous drop of all in-flight operations
//   in_valid   input operation present
//   in_ready   pipeline can accept input this cycle
//   in_rm      value to shift
//   in_rs      register shift amount source (bits [7:0] used)
//   in_shamt   immediate shift amount
//   in_sh      shift type: 00 LSL, 01 LSR, 10 ASR, 11 ROR/RRX
//   in_reg     1 = amount from in_rs[7:0], 0 = amount from in_shamt
//   in_cin     current C flag
//   in_tag     opaque tag
//   out_valid  result present
//   out_ready  consumer accepts the result
//   out_y      shifted result
//   out_cout   shifter carry-out
//   out_tag    tag of the result
module shifter_pipe #(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 2,
   parameter int TAG_W   = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_rm,
   input  logic [WIDTH-1:0]         in_rs,
   input  logic [$clog2(WIDTH)-1:0] in_shamt,
   input  logic [1:0]               in_sh,
   input  logic                     in_reg,
   input  logic                     in_cin,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_y,
   output logic                     out_cout,
   output logic [TAG_W-1:0]         out_tag
);

   localparam int         SH_W    = $clog2(WIDTH);
   localparam int         HALF    = SH_W / 2;
   localparam int         TAIL_LO = (LATENCY == 1) ? 0 : HALF;
   localparam logic [7:0] W8      = 8'(WIDTH);
   localparam logic [WIDTH-1:0] ONES = '1;

   localparam logic [1:0] SH_LSL = 2'b00;
   localparam logic [1:0] SH_LSR = 2'b01;
   localparam logic [1:0] SH_ASR = 2'b10;
   localparam logic [1:0] SH_ROR = 2'b11;

   // Every operation is normalised into a right shift or rotate of x by r.
   // LSL is done by reversing the operand, shifting right and reversing
   // back (rev). Out-of-range amounts and RRX are resolved during decode.
   // Those cases enter the network with r = 0 and a preformed x.
   // cout_sel picks the final y[W-1] as carry. That is the ROR rule.
   typedef struct packed {
      logic [WIDTH-1:0] x;
      logic [SH_W-1:0]  r;
      logic             rot;
      logic             fill;
      logic             rev;
      logic             carry;
      logic             cout_sel;
      logic [TAG_W-1:0] tag;
   } stage_t;

   function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] res;
      for (int i = 0; i < WIDTH; i++) res[i] = v[WIDTH-1-i];
      return res;
   endfunction

   // Applies mux levels lo..hi-1 of the log2(WIDTH)-level network.
   function automatic logic [WIDTH-1:0] shift_levels(
      input logic [WIDTH-1:0] x,
      input logic [SH_W-1:0]  r,
      input logic             rot,
      input logic             fill,
      input int               lo,
      input int               hi
   );
      logic [WIDTH-1:0] v;
      v = x;
      for (int k = 0; k < SH_W; k++) begin
         if (k >= lo && k < hi && r[k]) begin
            if (rot)
               v = (v >> (1 << k)) | (v << (WIDTH - (1 << k)));
            else if (fill)
               v = (v >> (1 << k)) | ~(ONES >> (1 << k));
            else
               v = v >> (1 << k);
         end
      end
      return v;
   endfunction

   function automatic stage_t advance(input stage_t p, input int lo, input int hi);
      stage_t q;
      q   = p;
      q.x = shift_levels(p.x, p.r, p.rot, p.fill, lo, hi);
      return q;
   endfunction

   logic adv;
   assign adv      = out_ready | ~out_valid;
   assign in_ready = adv;

   // Decode
   logic [7:0]       amt;
   logic [SH_W-1:0]  amt_lo;
   logic [SH_W-1:0]  amt_m1;
   logic [WIDTH-1:0] rm_rev;
   logic             sign;
   logic             is_rrx;
   stage_t           p_dec;

   always_comb begin
      rm_rev = bit_rev(in_rm);
      sign   = in_rm[WIDTH-1];
      is_rrx = ~in_reg && (in_shamt == '0) && (in_sh == SH_ROR);

      if (in_reg)
         amt = in_rs[7:0];
      else if ((in_shamt == '0) && ((in_sh == SH_LSR) || (in_sh == SH_ASR)))
         amt = W8;
      else
         amt = 8'(in_shamt);

      amt_lo = amt[SH_W-1:0];
      amt_m1 = amt_lo - SH_W'(1);

      p_dec     = '0;
      p_dec.tag = in_tag;

      if (is_rrx) begin
         p_dec.x     = {in_cin, in_rm[WIDTH-1:1]};
         p_dec.carry = in_rm[0];
      end else if (amt == 8'd0) begin
         p_dec.x     = in_rm;
         p_dec.carry = in_cin;
      end else begin
         case (in_sh)
            SH_LSL: begin
               p_dec.rev = 1'b1;
               if (amt < W8) begin
                  p_dec.x     = rm_rev;
                  p_dec.r     = amt_lo;
                  p_dec.carry = rm_rev[amt_m1];
               end else if (amt == W8) begin
                  p_dec.carry = in_rm[0];
               end
            end
            SH_LSR: begin
               if (amt < W8) begin
                  p_dec.x     = in_rm;
                  p_dec.r     = amt_lo;
                  p_dec.carry = in_rm[amt_m1];
               end else if (amt == W8) begin
                  p_dec.carry = sign;
               end
            end
            SH_ASR: begin
               if (amt < W8) begin
                  p_dec.x     = in_rm;
                  p_dec.r     = amt_lo;
                  p_dec.fill  = sign;
                  p_dec.carry = in_rm[amt_m1];
               end else begin
                  p_dec.x     = {WIDTH{sign}};
                  p_dec.carry = sign;
               end
            end
            SH_ROR: begin
               // amt mod WIDTH is just the low bits. r = 0 with amt != 0
               // leaves rm unrotated, and y[W-1] is then rm[W-1].
               p_dec.x        = in_rm;
               p_dec.r        = amt_lo;
               p_dec.rot      = 1'b1;
               p_dec.cout_sel = 1'b1;
            end
         endcase
      end
   end

   // Pipeline stages ahead of the output register
   stage_t p_tail;
   logic   v_pre;

   generate
      if (LATENCY == 1) begin : g_lat1
         assign p_tail = p_dec;
         assign v_pre  = in_valid;
      end else if (LATENCY == 2) begin : g_lat2
         stage_t s1;
         logic   s1_v;
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               s1   <= '0;
               s1_v <= 1'b0;
            end else if (flush) begin
               s1_v <= 1'b0;
            end else if (adv) begin
               s1   <= advance(p_dec, 0, HALF);
               s1_v <= in_valid;
            end
         end
         assign p_tail = s1;
         assign v_pre  = s1_v;
      end else begin : g_lat3
         stage_t s1;
         stage_t s2;
         logic   s1_v;
         logic   s2_v;
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               s1   <= '0;
               s2   <= '0;
               s1_v <= 1'b0;
               s2_v <= 1'b0;
            end else if (flush) begin
               s1_v <= 1'b0;
               s2_v <= 1'b0;
            end else if (adv) begin
               s1   <= p_dec;
               s1_v <= in_valid;
               s2   <= advance(s1, 0, HALF);
               s2_v <= s1_v;
            end
         end
         assign p_tail = s2;
         assign v_pre  = s2_v;
      end

      if (WIDTH > 8) begin : g_rs_hi
         logic unused_rs_hi;
         assign unused_rs_hi = ^in_rs[WIDTH-1:8];
      end
   endgenerate

   // Remaining levels, undo the LSL reversal, pick the carry
   logic [WIDTH-1:0] y_net;
   logic [WIDTH-1:0] y_fin;
   logic             cout_fin;

   always_comb begin
      y_net    = shift_levels(p_tail.x, p_tail.r, p_tail.rot, p_tail.fill, TAIL_LO, SH_W);
      y_fin    = p_tail.rev ? bit_rev(y_net) : y_net;
      cout_fin = p_tail.cout_sel ? y_fin[WIDTH-1] : p_tail.carry;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_y     <= '0;
         out_cout  <= 1'b0;
         out_tag   <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (adv) begin
         out_valid <= v_pre;
         out_y     <= y_fin;
         out_cout  <= cout_fin;
         out_tag   <= p_tail.tag;
      end
   end

endmodule

// File: tb/tb_shifter_pipe.sv
// Bench for shifter_pipe. Three copies of the DUT, with LATENCY 1, 2 and 3,
// share one stimulus stream. A scoreboard queue per copy is checked by a
// negedge monitor.
`timescale 1ns/1ps
module tb_shifter_pipe;
   localparam int W = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, flush, in_valid, out_ready, in_reg, in_cin;
   logic [W-1:0]  in_rm, in_rs;
   logic [4:0]    in_shamt;
   logic [1:0]    in_sh;
   logic [3:0]    in_tag;
   logic [2:0]    ir, ov, co;
   logic [W-1:0]  y_o [3];
   logic [3:0]    tg  [3];

   shifter_pipe #(.WIDTH(W), .LATENCY(1), .TAG_W(4)) u_lat1 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
      .in_rm(in_rm), .in_rs(in_rs), .in_shamt(in_shamt), .in_sh(in_sh), .in_reg(in_reg),
      .in_cin(in_cin), .in_tag(in_tag), .out_valid(ov[0]), .out_ready(out_ready),
      .out_y(y_o[0]), .out_cout(co[0]), .out_tag(tg[0]));

   shifter_pipe #(.WIDTH(W), .LATENCY(2), .TAG_W(4)) u_lat2 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
      .in_rm(in_rm), .in_rs(in_rs), .in_shamt(in_shamt), .in_sh(in_sh), .in_reg(in_reg),
      .in_cin(in_cin), .in_tag(in_tag), .out_valid(ov[1]), .out_ready(out_ready),
      .out_y(y_o[1]), .out_cout(co[1]), .out_tag(tg[1]));

   shifter_pipe #(.WIDTH(W), .LATENCY(3), .TAG_W(4)) u_lat3 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
      .in_rm(in_rm), .in_rs(in_rs), .in_shamt(in_shamt), .in_sh(in_sh), .in_reg(in_reg),
      .in_cin(in_cin), .in_tag(in_tag), .out_valid(ov[2]), .out_ready(out_ready),
      .out_y(y_o[2]), .out_cout(co[2]), .out_tag(tg[2]));

   typedef struct {
      logic [W-1:0] y;
      logic         c;
      logic [3:0]   tag;
      int           acc;
      bit           chk_lat;
   } exp_t;

   typedef struct {
      logic [W-1:0] rm;
      logic [W-1:0] rs;
      logic [4:0]   shamt;
      logic [1:0]   sh;
      logic         rg;
      logic         cin;
      logic [W-1:0] ey;
      logic         ec;
   } vec_t;

   exp_t sb0[$], sb1[$], sb2[$];
   vec_t vecs[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   bit   bp      = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s (LATENCY=%0d): actual %0h, required %0h", nm, i + 1, act, req);
      end
   endtask

   function automatic bit sb_pop(input int i, output exp_t e);
      e = '{y: '0, c: 1'b0, tag: '0, acc: 0, chk_lat: 1'b0};
      case (i)
         0: if (sb0.size() > 0) begin e = sb0.pop_front(); return 1'b1; end
         1: if (sb1.size() > 0) begin e = sb1.pop_front(); return 1'b1; end
         default: if (sb2.size() > 0) begin e = sb2.pop_front(); return 1'b1; end
      endcase
      return 1'b0;
   endfunction

   function automatic vec_t mk(input logic [W-1:0] rm, input logic [W-1:0] rs, input logic [4:0] shamt,
                               input logic [1:0] sh, input logic rg, input logic cin,
                               input logic [W-1:0] ey, input logic ec);
      vec_t v;
      v.rm = rm; v.rs = rs; v.shamt = shamt; v.sh = sh; v.rg = rg; v.cin = cin; v.ey = ey; v.ec = ec;
      return v;
   endfunction

   // Monitor
   logic [2:0]   prev_stall = '0;
   logic         prev_flush = 1'b0;
   logic [W-1:0] prev_y [3];
   logic [2:0]   prev_c;
   logic [3:0]   prev_t [3];
   exp_t         mon_e;

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (reset) begin
            chk("in_ready", i, 64'(ir[i]), 64'(!(ov[i] && !out_ready)));
            if (prev_stall[i] && !prev_flush) begin
               chk("hold_valid", i, 64'(ov[i]), 64'(1));
               chk("hold_y", i, 64'(y_o[i]), 64'(prev_y[i]));
               chk("hold_cout", i, 64'(co[i]), 64'(prev_c[i]));
               chk("hold_tag", i, 64'(tg[i]), 64'(prev_t[i]));
            end
            if (ov[i] && out_ready) begin
               if (!sb_pop(i, mon_e)) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_result (LATENCY=%0d): actual y=%0h tag=%0h, required no result",
                           i + 1, y_o[i], tg[i]);
               end else begin
                  chk("y", i, 64'(y_o[i]), 64'(mon_e.y));
                  chk("cout", i, 64'(co[i]), 64'(mon_e.c));
                  chk("tag", i, 64'(tg[i]), 64'(mon_e.tag));
                  if (mon_e.chk_lat) chk("latency", i, 64'(cyc - mon_e.acc), 64'(i + 1));
               end
            end
         end
         prev_stall[i] <= reset && ov[i] && !out_ready;
         prev_y[i]     <= y_o[i];
         prev_c[i]     <= co[i];
         prev_t[i]     <= tg[i];
      end
      prev_flush <= flush;
   end

   // Stimulus
   task automatic next_cycle();
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
   endtask

   task automatic drive(input vec_t v, input logic [3:0] tag);
      in_rm = v.rm; in_rs = v.rs; in_shamt = v.shamt; in_sh = v.sh;
      in_reg = v.rg; in_cin = v.cin; in_tag = tag;
   endtask

   task automatic issue(input vec_t v, input logic [3:0] tag);
      exp_t e;
      int   tries;
      tries = 0;
      next_cycle();
      while (ir != 3'b111) begin
         tries++;
         if (tries > 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: actual in_ready=%b, required 111", ir);
            return;
         end
         next_cycle();
      end
      drive(v, tag);
      in_valid = 1'b1;
      e.y = v.ey; e.c = v.ec; e.tag = tag; e.acc = cyc; e.chk_lat = !bp;
      sb0.push_back(e);
      sb1.push_back(e);
      sb2.push_back(e);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb0.size() + sb1.size() + sb2.size()) != 0 && n < 200) begin
         next_cycle();
         n++;
      end
      chk("drain_pending", 0, 64'(sb0.size() + sb1.size() + sb2.size()), 64'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: actual simulation still running, required finished");
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] tag;
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_rm = '0; in_rs = '0; in_shamt = '0; in_sh = '0; in_reg = 1'b0; in_cin = 1'b0; in_tag = '0;

      //            rm            rs            sh#  sh     reg   cin   y             cout
      vecs.push_back(mk(32'h80000001, 32'h0,        5'd0,  2'b01, 1'b0, 1'b0, 32'h00000000, 1'b1));
      vecs.push_back(mk(32'h80000000, 32'h0,        5'd0,  2'b10, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1));
      vecs.push_back(mk(32'h00000003, 32'h0,        5'd0,  2'b11, 1'b0, 1'b1, 32'h80000001, 1'b1));
      vecs.push_back(mk(32'h00000001, 32'd32,       5'd0,  2'b00, 1'b1, 1'b0, 32'h00000000, 1'b1));
      vecs.push_back(mk(32'h00000001, 32'd33,       5'd0,  2'b00, 1'b1, 1'b1, 32'h00000000, 1'b0));
      vecs.push_back(mk(32'h0000000F, 32'd36,       5'd0,  2'b11, 1'b1, 1'b0, 32'hF0000000, 1'b1));
      vecs.push_back(mk(32'h12345678, 32'd0,        5'd0,  2'b01, 1'b1, 1'b0, 32'h12345678, 1'b0));
      vecs.push_back(mk(32'hF0000010, 32'd4,        5'd0,  2'b10, 1'b1, 1'b1, 32'hFF000001, 1'b0));
      vecs.push_back(mk(32'hF0000010, 32'd4,        5'd0,  2'b01, 1'b1, 1'b1, 32'h0F000001, 1'b0));
      vecs.push_back(mk(32'h1800000F, 32'h0,        5'd4,  2'b00, 1'b0, 1'b0, 32'h800000F0, 1'b1));
      vecs.push_back(mk(32'h80000000, 32'd32,       5'd0,  2'b01, 1'b1, 1'b0, 32'h00000000, 1'b1));
      vecs.push_back(mk(32'hFFFFFFFF, 32'd40,       5'd0,  2'b01, 1'b1, 1'b1, 32'h00000000, 1'b0));
      vecs.push_back(mk(32'h7FFFFFFF, 32'd200,      5'd0,  2'b10, 1'b1, 1'b1, 32'h00000000, 1'b0));
      vecs.push_back(mk(32'h12345678, 32'h0,        5'd8,  2'b11, 1'b0, 1'b1, 32'h78123456, 1'b0));
      vecs.push_back(mk(32'h80000000, 32'd32,       5'd0,  2'b11, 1'b1, 1'b0, 32'h80000000, 1'b1));
      vecs.push_back(mk(32'h000000A5, 32'd0,        5'd0,  2'b00, 1'b1, 1'b1, 32'h000000A5, 1'b1));
      vecs.push_back(mk(32'h00000108, 32'h00000104, 5'd0,  2'b01, 1'b1, 1'b0, 32'h00000010, 1'b1));
      vecs.push_back(mk(32'h80000000, 32'h0,        5'd31, 2'b10, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0));
      vecs.push_back(mk(32'h80000001, 32'h0,        5'd0,  2'b11, 1'b0, 1'b0, 32'h40000000, 1'b1));

      // Reset state, held from time zero
      #2;
      for (int i = 0; i < 3; i++) begin
         chk("reset_out_valid", i, 64'(ov[i]), 64'(0));
         chk("reset_out_y", i, 64'(y_o[i]), 64'(0));
         chk("reset_out_cout", i, 64'(co[i]), 64'(0));
         chk("reset_out_tag", i, 64'(tg[i]), 64'(0));
         chk("reset_in_ready", i, 64'(ir[i]), 64'(1));
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Directed vectors, out_ready held high
      tag = 4'd0;
      foreach (vecs[k]) begin
         issue(vecs[k], tag);
         tag = tag + 4'd1;
      end
      drain();

      // Backpressure: eight tagged operations with a random out_ready
      bp = 1'b1;
      for (int k = 0; k < 8; k++) issue(vecs[k], 4'(k));
      drain();
      bp = 1'b0;

      // Flush with ops in flight and one more presented in the flush cycle
      next_cycle();
      out_ready = 1'b0; drive(vecs[3], 4'hA); in_valid = 1'b1;
      next_cycle();
      out_ready = 1'b0; drive(vecs[4], 4'hB); in_valid = 1'b1;
      next_cycle();
      out_ready = 1'b0; drive(vecs[5], 4'hC); in_valid = 1'b1; flush = 1'b1;
      next_cycle();
      for (int i = 0; i < 3; i++) chk("flush_out_valid", i, 64'(ov[i]), 64'(0));
      repeat (6) next_cycle();
      for (int i = 0; i < 3; i++) chk("flush_no_emerge", i, 64'(ov[i]), 64'(0));

      // Asynchronous reset with operations in flight
      issue(vecs[7], 4'h5);
      issue(vecs[8], 4'h6);
      next_cycle();
      #1 reset = 1'b0;
      sb0.delete();
      sb1.delete();
      sb2.delete();
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("async_reset_valid", i, 64'(ov[i]), 64'(0));
         chk("async_reset_y", i, 64'(y_o[i]), 64'(0));
      end
      next_cycle();
      next_cycle();
      reset = 1'b1;
      repeat (8) next_cycle();
      for (int i = 0; i < 3; i++) chk("no_stale_after_reset", i, 64'(ov[i]), 64'(0));

      // Pipeline still works after reset
      issue(vecs[5], 4'h9);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
